// File: rtl/fp16_pkg.sv
// fp16_pkg: shared definitions for IEEE-754 half-precision arithmetic blocks.
//   Field widths, encoding constants, word layout and the divider FSM state.
package fp16_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned WORD_W = SIGN_W + EXP_W + FRAC_W;

    localparam int unsigned BIAS    = 15;
    localparam int unsigned EXP_MAX = 31;

    localparam logic [WORD_W-1:0] INF  = 16'h7C00;
    localparam logic [WORD_W-1:0] QNAN = 16'h7E00;

    // Half-precision word layout
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        DIVIDE = 2'd2,
        NORM   = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_unpack.sv
// fp16_unpack: combinational field extraction for one half-precision operand.
//   word       : input  16-bit half-precision value
//   sign       : output sign bit
//   exp        : output biased exponent
//   mant       : output 11-bit mantissa 1.frac (zero when exponent is zero)
//   is_zero    : output exponent is zero (subnormals flushed to zero)
//   is_special : output exponent is all ones (infinity or NaN)
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_special
);

    fp16_t f;

    assign f          = fp16_t'(word);
    assign sign       = f.sign;
    assign exp        = f.exp;
    assign is_zero    = (f.exp == '0);
    assign is_special = (f.exp == EXP_W'(EXP_MAX));
    assign mant       = is_zero ? '0 : {1'b1, f.frac};

endmodule

// File: rtl/divider_multi_cycle.sv
// divider_multi_cycle: half-precision divider, one quotient bit per cycle.
//   Fixed latency: result strobe ITER+2 edges after the capture edge.
//   clk           : input  rising-edge clock
//   rst           : input  asynchronous active-high reset
//   i_valid       : input  operand strobe, accepted only while o_busy is low
//   i_a, i_b      : input  dividend / divisor (half precision)
//   o_busy        : output operation in flight (through the strobe cycle)
//   o_res         : output quotient, held until the next strobe
//   Overflow      : output quotient exceeded max finite, result is signed inf
//   o_div_by_zero : output finite nonzero dividend divided by zero
//   o_res_vld     : output one-cycle result strobe
module divider_multi_cycle
    import fp16_pkg::*;
#(
    parameter int unsigned ITER = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_res,
    output logic              Overflow,
    output logic              o_div_by_zero,
    output logic              o_res_vld
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned REM_W = MANT_W + 1;
    localparam int unsigned QE_W  = 7;
    localparam int unsigned Q_W   = ITER - 1;

    localparam logic signed [QE_W-1:0] EXP_OFF  = QE_W'(BIAS);
    localparam logic signed [QE_W-1:0] EXP_TOP  = QE_W'(EXP_MAX - 1);
    localparam logic signed [QE_W-1:0] EXP_LOW  = QE_W'(1);

    state_t state;

    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;

    logic                   sign_q;
    logic signed [QE_W-1:0] exp_q;
    logic [REM_W-1:0]       rem_q;
    logic [MANT_W-1:0]      mb_q;
    logic [Q_W-1:0]         quo_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sp_q;
    logic [WORD_W-1:0]      sp_res_q;
    logic                   sp_dbz_q;

    // Operand field extraction
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MANT_W-1:0] ma, mb;
    logic              za, zb;
    logic              xa, xb;

    fp16_unpack u_unpack_a (
        .word       (a_q),
        .sign       (sa),
        .exp        (ea),
        .mant       (ma),
        .is_zero    (za),
        .is_special (xa)
    );

    fp16_unpack u_unpack_b (
        .word       (b_q),
        .sign       (sb),
        .exp        (eb),
        .mant       (mb),
        .is_zero    (zb),
        .is_special (xb)
    );

    // Unpack-stage arithmetic and special-case classification
    logic                   sign_c;
    logic signed [QE_W-1:0] ea_s, eb_s, exp_diff, exp_adj;
    logic                   mant_lt;
    logic [REM_W-1:0]       rem_init;
    logic                   sp_c;
    logic [WORD_W-1:0]      sp_res_c;
    logic                   sp_dbz_c;

    always_comb begin
        sign_c   = sa ^ sb;
        ea_s     = {2'b00, ea};
        eb_s     = {2'b00, eb};
        exp_diff = ea_s - eb_s + EXP_OFF;
        mant_lt  = (ma < mb);
        // Pre-shift so the quotient lands in [1,2) and its first bit is always 1
        exp_adj  = mant_lt ? (exp_diff - QE_W'(1)) : exp_diff;
        rem_init = mant_lt ? {ma, 1'b0} : {1'b0, ma};

        sp_c     = 1'b1;
        sp_res_c = '0;
        sp_dbz_c = 1'b0;
        if (xa || xb) begin
            sp_res_c = QNAN;
        end else if (za && zb) begin
            sp_res_c = QNAN;
        end else if (zb) begin
            sp_res_c = {sign_c, INF[WORD_W-2:0]};
            sp_dbz_c = 1'b1;
        end else if (za) begin
            sp_res_c = {sign_c, {(WORD_W-1){1'b0}}};
        end else begin
            sp_c = 1'b0;
        end
    end

    // Restoring division step
    logic             ge;
    logic [REM_W-1:0] rem_sel;
    logic [REM_W-1:0] rem_next;

    always_comb begin
        ge       = (rem_q >= {1'b0, mb_q});
        rem_sel  = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_next = rem_sel << 1;
    end

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            rem_q         <= '0;
            mb_q          <= '0;
            quo_q         <= '0;
            cnt           <= '0;
            sp_q          <= 1'b0;
            sp_res_q      <= '0;
            sp_dbz_q      <= 1'b0;
            o_busy        <= 1'b0;
            o_res         <= '0;
            Overflow      <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_res_vld     <= 1'b0;
        end else begin
            o_res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    // Busy is still high during the strobe cycle, so the
                    // edge right after a result never captures.
                    if (o_busy) begin
                        o_busy <= 1'b0;
                    end else if (i_valid) begin
                        a_q    <= i_a;
                        b_q    <= i_b;
                        o_busy <= 1'b1;
                        state  <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q   <= sign_c;
                    exp_q    <= exp_adj;
                    rem_q    <= rem_init;
                    mb_q     <= mb;
                    quo_q    <= '0;
                    cnt      <= '0;
                    sp_q     <= sp_c;
                    sp_res_q <= sp_res_c;
                    sp_dbz_q <= sp_dbz_c;
                    state    <= DIVIDE;
                end
                DIVIDE: begin
                    // Leading quotient bit falls off the top; only the fraction is kept
                    rem_q <= rem_next;
                    quo_q <= {quo_q[Q_W-2:0], ge};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    o_res_vld <= 1'b1;
                    state     <= IDLE;
                    if (sp_q) begin
                        o_res         <= sp_res_q;
                        Overflow      <= 1'b0;
                        o_div_by_zero <= sp_dbz_q;
                    end else if (exp_q > EXP_TOP) begin
                        o_res         <= {sign_q, INF[WORD_W-2:0]};
                        Overflow      <= 1'b1;
                        o_div_by_zero <= 1'b0;
                    end else if (exp_q < EXP_LOW) begin
                        o_res         <= {sign_q, {(WORD_W-1){1'b0}}};
                        Overflow      <= 1'b0;
                        o_div_by_zero <= 1'b0;
                    end else begin
                        o_res         <= {sign_q, EXP_W'(exp_q), quo_q[Q_W-1 -: FRAC_W]};
                        Overflow      <= 1'b0;
                        o_div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_multi_cycle.sv
// tb_divider_multi_cycle: directed self-checking bench for divider_multi_cycle.
module tb_divider_multi_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_busy;
    logic [15:0] o_res;
    logic        Overflow;
    logic        o_div_by_zero;
    logic        o_res_vld;

    int vectors    = 0;
    int miscompares = 0;

    divider_multi_cycle #(.ITER(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_a           (i_a),
        .i_b           (i_b),
        .o_busy        (o_busy),
        .o_res         (o_res),
        .Overflow      (Overflow),
        .o_div_by_zero (o_div_by_zero),
        .o_res_vld     (o_res_vld)
    );

    always #5 clk = ~clk;

    // Launch one operation and report busy after capture and strobe latency in edges
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit release_rst,
                         output int lat, output logic busy0);
        if (!release_rst) @(posedge clk);
        @(negedge clk);
        if (release_rst) rst = 1'b0;
        i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        busy0 = o_busy;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_res_vld) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({o_busy, o_res_vld, Overflow, o_div_by_zero, o_res} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 00000",
                     {o_busy, o_res_vld, Overflow, o_div_by_zero, o_res});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic busy0;
        do_op(16'h4600, 16'h4000, 1'b0, lat, busy0);
        vectors++;
        if (busy0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_capture: got %b expected 1", busy0); end
        vectors++;
        if (lat !== 13) begin miscompares++; $display("FAIL basic_latency: got %0d expected 13", lat); end
        vectors++;
        if (o_res !== 16'h4200) begin miscompares++; $display("FAIL basic_res: got %h expected 4200", o_res); end
        vectors++;
        if ({Overflow, o_div_by_zero} !== 2'b00) begin miscompares++; $display("FAIL basic_flags: got %b expected 00", {Overflow, o_div_by_zero}); end
        vectors++;
        if (o_busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_at_strobe: got %b expected 1", o_busy); end
        @(posedge clk); #1;
        vectors++;
        if ({o_busy, o_res_vld} !== 2'b00) begin miscompares++; $display("FAIL basic_after_strobe: got %b expected 00", {o_busy, o_res_vld}); end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (o_res !== 16'h4200) begin miscompares++; $display("FAIL basic_hold: got %h expected 4200", o_res); end
    endtask

    task automatic test_signed();
        int lat; logic busy0;
        do_op(16'hC780, 16'h4100, 1'b0, lat, busy0);
        vectors++;
        if (lat !== 13 || o_res !== 16'hC200) begin
            miscompares++; $display("FAIL signed: got res %h lat %0d expected C200 lat 13", o_res, lat);
        end
    endtask

    task automatic test_truncate();
        int lat; logic busy0;
        do_op(16'h3C00, 16'h4200, 1'b0, lat, busy0);
        vectors++;
        if (lat !== 13 || o_res !== 16'h3555) begin
            miscompares++; $display("FAIL truncate: got res %h lat %0d expected 3555 lat 13", o_res, lat);
        end
    endtask

    task automatic test_overflow();
        int lat; logic busy0;
        do_op(16'h7BFF, 16'h3800, 1'b0, lat, busy0);
        vectors++;
        if (lat !== 13 || {o_res, Overflow, o_div_by_zero} !== {16'h7C00, 2'b10}) begin
            miscompares++; $display("FAIL overflow: got res %h ovf %b dbz %b lat %0d expected 7C00 1 0 13",
                                    o_res, Overflow, o_div_by_zero, lat);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic busy0;
        do_op(16'h4500, 16'h0000, 1'b0, lat, busy0);
        vectors++;
        if (lat !== 13 || {o_res, Overflow, o_div_by_zero} !== {16'h7C00, 2'b01}) begin
            miscompares++; $display("FAIL div_zero: got res %h ovf %b dbz %b lat %0d expected 7C00 0 1 13",
                                    o_res, Overflow, o_div_by_zero, lat);
        end
        do_op(16'h0000, 16'h0000, 1'b0, lat, busy0);
        vectors++;
        if (lat !== 13 || {o_res, Overflow, o_div_by_zero} !== {16'h7E00, 2'b00}) begin
            miscompares++; $display("FAIL zero_by_zero: got res %h ovf %b dbz %b lat %0d expected 7E00 0 0 13",
                                    o_res, Overflow, o_div_by_zero, lat);
        end
    endtask

    task automatic test_specials();
        // dividend, divisor, expected result, expected {Overflow, o_div_by_zero}
        logic [15:0] va [6] = '{16'h0000, 16'h8400, 16'h7C00, 16'h0001, 16'hC000, 16'h4000};
        logic [15:0] vb [6] = '{16'hC000, 16'h7800, 16'h4000, 16'h4000, 16'h0000, 16'h7E00};
        logic [15:0] vr [6] = '{16'h8000, 16'h8000, 16'h7E00, 16'h0000, 16'hFC00, 16'h7E00};
        logic [1:0]  vf [6] = '{2'b00,    2'b00,    2'b00,    2'b00,    2'b01,    2'b00};
        int lat; logic busy0;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], 1'b0, lat, busy0);
            vectors++;
            if (lat !== 13 || {o_res, Overflow, o_div_by_zero} !== {vr[i], vf[i]}) begin
                miscompares++;
                $display("FAIL special_%0d: %h/%h got res %h flags %b lat %0d expected %h %b 13",
                         i, va[i], vb[i], o_res, {Overflow, o_div_by_zero}, lat, vr[i], vf[i]);
            end
        end
    endtask

    task automatic test_ignore();
        int lat; int strobes;
        @(posedge clk);
        @(negedge clk); i_a = 16'h4600; i_b = 16'h4000; i_valid = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;          // edge k
        repeat (2) @(posedge clk);                   // edges k+1, k+2
        @(negedge clk); i_a = 16'h3C00; i_b = 16'h4200; i_valid = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;          // edge k+3, ignored
        lat = -1;
        for (int i = 4; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_res_vld) begin lat = i; break; end
        end
        vectors++;
        if (lat !== 13 || o_res !== 16'h4200) begin
            miscompares++; $display("FAIL ignore_in_flight: got res %h lat %0d expected 4200 lat 13", o_res, lat);
        end
        // Strobe cycle still reports busy, so a request at the next edge is dropped
        @(negedge clk); i_a = 16'h3C00; i_b = 16'h4200; i_valid = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (o_res_vld) strobes++;
        end
        vectors++;
        if (strobes !== 0) begin miscompares++; $display("FAIL back_to_back_drop: got %0d strobes expected 0", strobes); end
    endtask

    task automatic test_reset_mid();
        int lat; logic busy0;
        @(posedge clk);
        @(negedge clk); i_a = 16'h4600; i_b = 16'h4000; i_valid = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;          // edge k
        repeat (6) @(posedge clk);                   // edge k+6
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({o_busy, o_res_vld, Overflow, o_div_by_zero, o_res} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h expected 00000",
                     {o_busy, o_res_vld, Overflow, o_div_by_zero, o_res});
        end
        @(posedge clk);
        // Release reset and capture on the very next edge; an aborted op would strobe early
        do_op(16'h3C00, 16'h4200, 1'b1, lat, busy0);
        vectors++;
        if (busy0 !== 1'b1) begin miscompares++; $display("FAIL post_reset_capture: got busy %b expected 1", busy0); end
        vectors++;
        if (lat !== 13 || o_res !== 16'h3555) begin
            miscompares++; $display("FAIL post_reset_result: got res %h lat %0d expected 3555 lat 13", o_res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_truncate();
        test_overflow();
        test_div_zero();
        test_specials();
        test_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
